// File: rtl/lane_rr_arbiter.sv
// Round-robin scheduler sharing one byte channel between two show-ahead FIFOs, bursting with
// valid-low gaps between bursts. Define ARB_STATS_EN to add saturating per-port pop counters.
module lane_rr_arbiter #(
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        clk8f,
    input  logic        reset,
    input  logic        fifo_empty_0,
    input  logic [7:0]  fifo_data_0,
    input  logic        fifo_empty_1,
    input  logic [7:0]  fifo_data_1,
    input  logic        almost_full,
    output logic        pop_0,
    output logic        pop_1,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic [1:0]  grant
`ifdef ARB_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] byte_cnt_0,
    output logic [15:0] byte_cnt_1
`endif
);

    typedef enum logic [1:0] {StIdle, StServe0, StServe1, StGap} state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);
    localparam logic [2:0] GapLast  = 3'(GAP_CYCLES - 1);

    state_e     state_q;
    logic [3:0] burst_cnt_q;
    logic [2:0] gap_cnt_q;
    logic       last_grant_q;
    logic       burst_room;

    assign burst_room = (burst_cnt_q < MaxBurst);

    // Only the SERVE state of a port may pop it, so the two pops are mutually exclusive.
    assign pop_0 = !reset && (state_q == StServe0) && !fifo_empty_0 && !almost_full && burst_room;
    assign pop_1 = !reset && (state_q == StServe1) && !fifo_empty_1 && !almost_full && burst_room;

    assign grant = {state_q == StServe1, state_q == StServe0};

    always_ff @(posedge clk8f) begin
        if (reset) begin
            state_q      <= StIdle;
            burst_cnt_q  <= 4'd0;
            gap_cnt_q    <= 3'd0;
            last_grant_q <= 1'b1;
            data_out     <= 8'h00;
            valid_out    <= 1'b0;
        end else begin
            valid_out <= pop_0 | pop_1;
            if (pop_0) begin
                data_out <= fifo_data_0;
            end else if (pop_1) begin
                data_out <= fifo_data_1;
            end

            case (state_q)
                StIdle: begin
                    // Port 0 wins when it is the only requester or when port 1 went last.
                    if (!fifo_empty_0 && (fifo_empty_1 || last_grant_q)) begin
                        state_q      <= StServe0;
                        burst_cnt_q  <= 4'd0;
                        last_grant_q <= 1'b0;
                    end else if (!fifo_empty_1) begin
                        state_q      <= StServe1;
                        burst_cnt_q  <= 4'd0;
                        last_grant_q <= 1'b1;
                    end
                end
                StServe0, StServe1: begin
                    if (pop_0 || pop_1) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end else begin
                        state_q   <= StGap;
                        gap_cnt_q <= 3'd0;
                    end
                end
                StGap: begin
                    gap_cnt_q <= gap_cnt_q + 3'd1;
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk8f) begin
        if (reset || stats_clr) begin
            byte_cnt_0 <= 16'h0000;
            byte_cnt_1 <= 16'h0000;
        end else begin
            if (pop_0 && (byte_cnt_0 != 16'hFFFF)) begin
                byte_cnt_0 <= byte_cnt_0 + 16'd1;
            end
            if (pop_1 && (byte_cnt_1 != 16'hFFFF)) begin
                byte_cnt_1 <= byte_cnt_1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/lane_rr_arbiter.md
Name: lane_rr_arbiter

Overview:
- Round-robin scheduler that shares the single 8-bit byte channel feeding the lane demultiplexer between two source FIFOs.
- Pops bytes from the granted FIFO in bounded bursts and presents them as data/valid on the shared channel.
- Always inserts valid-low gaps between bursts, because the downstream demux switches lanes only on a valid gap.
- Sits between the source FIFOs and the demux input, in the clk8f domain.

Parameters:
MAX_BURST, 4, maximum bytes popped per grant (1..15)
GAP_CYCLES, 1, GAP-state cycles inserted after each burst (1..7)

Ports:
clk8f  input  1  clock
reset  input  1  synchronous reset, active-high
fifo_empty_0  input  1  source FIFO 0 empty
fifo_data_0  input  8  FIFO 0 head byte (show-ahead, valid when not empty)
fifo_empty_1  input  1  source FIFO 1 empty
fifo_data_1  input  8  FIFO 1 head byte (show-ahead)
almost_full  input  1  downstream back-pressure
pop_0  output  1  consume FIFO 0 head this cycle (combinational)
pop_1  output  1  consume FIFO 1 head this cycle (combinational)
data_out  output  8  byte to shared channel (registered)
valid_out  output  1  data_out valid (registered)
grant  output  2  one-hot current owner, decoded from state

Behaviour:
- Reset: synchronous, active-high on clk8f. Clock is clk8f.
  - Reset values: state=IDLE, data_out=0, valid_out=0, grant=00, burst_cnt=0, last_grant=1 (port 0 wins first).
  - pop_0/pop_1 forced 0 while reset=1.
  - Reset mid-burst aborts the burst. Bytes already popped are still output on the next edge only if reset is low then; otherwise they are dropped.
- States: IDLE, SERVE_0, SERVE_1, GAP.
- IDLE (arbitration, never pops):
  - Both FIFOs non-empty -> SERVE of the port != last_grant.
  - One FIFO non-empty -> SERVE of that port.
  - None non-empty -> stay in IDLE.
  - On entering SERVE_x: burst_cnt<=0, last_grant<=x.
- SERVE_x:
  - pop_x = !fifo_empty_x && !almost_full && burst_cnt<MAX_BURST.
  - If pop_x: burst_cnt++, stay in SERVE_x.
  - Else: go to GAP, gap_cnt<=0.
  - pop of the non-granted port is always 0.
- GAP: no pop; gap_cnt++. When gap_cnt==GAP_CYCLES-1, go to IDLE.
- Datapath, latency 1: on each edge, valid_out<=pop_0|pop_1; data_out<=pop_0?fifo_data_0:pop_1?fifo_data_1:data_out (hold).
- Gap rule: every burst is followed by exactly GAP_CYCLES+2 valid_out-low cycles before the next burst. This holds even when the same port is re-granted.
- almost_full in SERVE ends the burst; there is never a valid-low bubble inside a burst. almost_full in IDLE does not block arbitration. The new SERVE state immediately ends if almost_full is still high (zero-length burst, then GAP).
- FIFO becoming empty mid-burst ends the burst the same way.
- Simultaneous requests are resolved strictly alternately. A single active requester is re-granted indefinitely, but always with gaps.
- Width rules:
  - burst_cnt is 4 bits; gap_cnt is 3 bits; neither ever wraps (bounded by parameters).
  - pop_0 and pop_1 are never both 1.
  - grant is 01 in SERVE_0, 10 in SERVE_1, 00 otherwise.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs byte_cnt_0[15:0] and byte_cnt_1[15:0], each incremented by 1 per pop of its port.
  - Saturating at 16'hFFFF; cleared by reset.
  - Adds input stats_clr (synchronous clear, priority over increment).
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. reset=1 for 2 edges with both FIFOs non-empty -> pop_0=pop_1=0, valid_out=0, data_out=00, grant=00; first grant after release goes to port 0.
2. FIFO0 holds A1,A2,A3; FIFO1 empty; MAX_BURST=4 -> 1 IDLE cycle, pop_0 high 3 cycles; valid_out high 3 cycles carrying A1,A2,A3 one cycle after each pop; then GAP and IDLE.
3. Both FIFOs hold 8 bytes (0x10.., 0x20..); MAX_BURST=4, GAP_CYCLES=1 -> valid_out shows 10,11,12,13, 3 low cycles, 20,21,22,23, 3 low cycles, then 14..17.
4. Both non-empty; almost_full rises after 2 pops of port 0 and falls 2 cycles later -> exactly 2 bytes out, GAP; next burst granted to port 1.
5. reset asserted in the cycle of the 3rd pop of a 4-byte burst -> next edge: valid_out=0, state IDLE, last_grant=1; the 3rd byte is dropped.
6. With ARB_STATS_EN: 5 pops on port 0 and 3 on port 1 -> byte_cnt_0=5, byte_cnt_1=3; stats_clr pulse -> both 0; preload near 16'hFFFF and pop -> holds at FFFF.
